alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Two-stage execute sequencer. It decodes an instruction word plus register operands and drives `f3_i`, `f7_i`, `op1_i` and `op2_i` of the CPU's combinational `alu` from registered state.
- It captures the ALU result and flags one cycle later and resolves branch decisions.
- It sits between the decode/register-read stage and writeback/fetch-redirect, with valid/ready handshakes on both sides.

Parameters:
- SIZE, 32, datapath width; must equal the `alu` SIZE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  synchronous kill of both stages
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  stage 1 can accept this cycle
- in_instr  in  32  RISC-V instruction word
- in_pc  in  SIZE  instruction address
- in_rs1  in  SIZE  rs1 register value
- in_rs2  in  SIZE  rs2 register value
- out_valid  out  1  stage 2 holds a result
- out_ready  in  1  downstream consumes the result
- out_result  out  SIZE  captured ALU result
- out_rd  out  5  destination register; 0 for branches
- out_we  out  1  register write enable; 1 for R/I ALU ops only
- out_br_taken  out  1  branch resolved taken
- out_br_target  out  SIZE  in_pc + B-immediate
- out_illegal  out  1  unsupported opcode or funct3

Behaviour:
- Reset (async, rst=1): all `*_valid` registers, the stage-1 ALU-operand registers and all out_* data registers go to 0. in_ready is 1 after reset.
- Handshake, stage 1 to stage 2:
  - s2_adv = !out_valid | out_ready.
  - in_ready = !s1_valid | s2_adv.
  - Accept when in_valid & in_ready.
  - Data registers load only on their stage's advance and otherwise hold.
- Flush: on a clock edge with flush=1, s1_valid and out_valid clear. Flush beats a simultaneous accept; nothing is captured that cycle.
- Stage 1 (issue), on accept, registers the ALU inputs by opcode (in_instr[6:0]):
  - R-type 0110011: op1=rs1, op2=rs2, f3=instr[14:12], f7=instr[31:25].
  - I-type 0010011: op1=rs1, op2=sext(instr[31:20]), f3=instr[14:12], f7=0. ADDI must never subtract.
  - B-type 1100011: op1=rs1, op2=rs2, f3=`F3_ADD_SUB`, f7=0100000 (subtract). The original funct3 is kept as br_f3.
  - The branch target pc+sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}) is computed here, modulo 2^SIZE.
  - Any other opcode, or an ALU funct3 not among ADD_SUB/AND/OR/XOR: set illegal and zero the operands.
- ALU path: the `alu` is combinational from the stage-1 registers. Its rst input is tied to 0; stage-1 reset already forces zero operands.
- Stage 2 (capture), on s2_adv with s1_valid:
  - out_result = alu.
  - out_rd = instr[11:7] for R/I types, else 0.
  - out_we = R/I & !illegal.
  - out_valid = s1_valid.
- Branch resolution on the subtract result r = op1-op2, with flags c, z, n from `alu`:
  - Compute vs = (op1[SIZE-1]^op2[SIZE-1]) & (op1[SIZE-1]^r[SIZE-1]) locally. The ALU's v flag is add-overflow only and must not be used.
  - beq=z; bne=!z; blt=n^vs; bge=!(n^vs); bltu=c; bgeu=!c.
  - c is the borrow: bit SIZE of the (SIZE+1)-bit difference.
  - br_f3 010/011 is illegal, with taken=0.
  - out_br_taken = 0 for non-branches.
- Latency: accept at edge k gives out_valid at edge k+1 when unstalled. Throughput is 1 per cycle.
- Backpressure: with out_valid=1 and out_ready=0, stage 2 holds all outputs stable. Stage 1 holds, and in_ready drops once s1_valid=1.
- Simultaneous events: a same-cycle consume plus accept behaves as a full pipeline advance.
- Illegal instruction: still flows through the pipeline with out_illegal=1, out_we=0, out_br_taken=0.
- Reset mid-operation clears in-flight work immediately; no partial output survives.

Decomposition:
- `cpu/define.v` gains the opcode constants OP_R, OP_I and OP_B, plus `F3_BEQ`..`F3_BGEU` and `F7_SUB`. It reuses `Funct3Bus`, `Funct7Bus` and the `F3_*` ALU codes.
- One sub-module: the existing `alu`, instantiated once. Immediate generation stays inline.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7 → out_result=12, out_rd=3, out_we=1, one cycle after accept.
- SUB with rs1=3, rs2=5 → out_result=0xFFFFFFFE. ADDI with imm=-1 (0xFFF) and rs1=1 → out_result=0, even though instr[30]=1.
- BLT/BLTU with rs1=0xFFFFFFFF, rs2=1 → BLT taken=1, BLTU taken=0. BGE with rs1=0x80000000, rs2=1 → taken=0, checking vs overflow handling. BEQ with equal values → taken=1, out_we=0.
- Branch at pc=0x100 with imm=-8 → out_br_target=0xF8. At pc=0xFFFFFFFC with imm=+8 → 0x4 (wrap).
- Back-to-back stream with out_ready held low for 3 cycles → in_ready=0 after one buffered instruction, outputs stable, no loss or duplication after release.
- flush asserted together with in_valid, and rst pulsed mid-stream → out_valid=0 next edge. An opcode such as 0000011 yields out_illegal=1, out_we=0.

Source files
------------

// File: rtl/alu_exec_stage_pkg.sv
// Shared decode constants and small helpers for the execute stage and its ALU.
// Opcode/funct encodings follow the RV32I base ISA.
package alu_exec_stage_pkg;

    typedef logic [6:0] opcode_t;
    typedef logic [2:0] funct3_t;
    typedef logic [6:0] funct7_t;

    localparam opcode_t OP_R = 7'b0110011;
    localparam opcode_t OP_I = 7'b0010011;
    localparam opcode_t OP_B = 7'b1100011;

    localparam funct3_t F3_ADD_SUB = 3'b000;
    localparam funct3_t F3_XOR     = 3'b100;
    localparam funct3_t F3_OR      = 3'b110;
    localparam funct3_t F3_AND     = 3'b111;

    localparam funct3_t F3_BEQ  = 3'b000;
    localparam funct3_t F3_BNE  = 3'b001;
    localparam funct3_t F3_BLT  = 3'b100;
    localparam funct3_t F3_BGE  = 3'b101;
    localparam funct3_t F3_BLTU = 3'b110;
    localparam funct3_t F3_BGEU = 3'b111;

    localparam funct7_t F7_ZERO = 7'b0000000;
    localparam funct7_t F7_SUB  = 7'b0100000;

    function automatic logic alu_f3_legal(input funct3_t f3);
        return (f3 == F3_ADD_SUB) || (f3 == F3_AND) || (f3 == F3_OR) || (f3 == F3_XOR);
    endfunction

    // 010 and 011 are the only unassigned branch funct3 codes.
    function automatic logic br_f3_legal(input funct3_t f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational ALU: add/sub/and/or/xor with carry(borrow), zero, negative and
// add-overflow flags. rst forces a zero result.
module alu
    import alu_exec_stage_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            rst,
    input  funct3_t         f3,
    input  funct7_t         f7,
    input  logic [SIZE-1:0] op1,
    input  logic [SIZE-1:0] op2,
    output logic [SIZE-1:0] result,
    output logic            c,
    output logic            z,
    output logic            n,
    output logic            v
);

    logic [SIZE:0]   sum_ext;
    logic [SIZE:0]   diff_ext;
    logic [SIZE-1:0] and_v;
    logic [SIZE-1:0] or_v;
    logic [SIZE-1:0] xor_v;
    logic            sub;

    assign sum_ext  = {1'b0, op1} + {1'b0, op2};
    assign diff_ext = {1'b0, op1} - {1'b0, op2};
    assign sub      = (f7 == F7_SUB);

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_bitwise
        assign and_v[gi] = op1[gi] & op2[gi];
        assign or_v[gi]  = op1[gi] | op2[gi];
        assign xor_v[gi] = op1[gi] ^ op2[gi];
    end

    // On subtract, c is bit SIZE of the widened difference, i.e. the borrow.
    always_comb begin
        result = '0;
        c      = 1'b0;
        if (!rst) begin
            case (f3)
                F3_ADD_SUB: begin
                    if (sub) begin
                        {c, result} = diff_ext;
                    end else begin
                        {c, result} = sum_ext;
                    end
                end
                F3_AND:  result = and_v;
                F3_OR:   result = or_v;
                F3_XOR:  result = xor_v;
                default: result = '0;
            endcase
        end
    end

    assign z = (result == '0);
    assign n = result[SIZE-1];
    assign v = !rst & ~(op1[SIZE-1] ^ op2[SIZE-1]) & (op1[SIZE-1] ^ sum_ext[SIZE-1]);

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage execute sequencer: stage 1 decodes and registers ALU operands,
// stage 2 captures the ALU result and resolves branches.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [SIZE-1:0] in_pc,
    input  logic [SIZE-1:0] in_rs1,
    input  logic [SIZE-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_br_taken,
    output logic [SIZE-1:0] out_br_target,
    output logic            out_illegal
);

    logic            s1_valid_reg;
    logic [SIZE-1:0] op1_reg, op2_reg, br_target_reg;
    funct3_t         f3_reg, br_f3_reg;
    funct7_t         f7_reg;
    logic [4:0]      rd_reg;
    logic            is_alu_reg, is_branch_reg, illegal_reg;

    logic [SIZE-1:0] op1_next, op2_next, br_target_next;
    funct3_t         f3_next, br_f3_next;
    funct7_t         f7_next;
    logic [4:0]      rd_next;
    logic            is_alu_next, is_branch_next, illegal_next;

    logic            s2_adv, accept;
    opcode_t         opcode;
    funct3_t         in_f3;
    logic [SIZE-1:0] imm_i, imm_b;
    logic [4:0]      rs1_field_unused;

    logic [SIZE-1:0] alu_result;
    logic            alu_c, alu_z, alu_n, alu_v_unused;
    logic            vs, br_cond, br_taken;

    assign s2_adv   = !out_valid | out_ready;
    assign in_ready = !s1_valid_reg | s2_adv;
    assign accept   = in_valid & in_ready & !flush;

    assign opcode           = in_instr[6:0];
    assign in_f3            = in_instr[14:12];
    assign rs1_field_unused = in_instr[19:15];
    assign imm_i = {{(SIZE-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_b = {{(SIZE-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign br_target_next = in_pc + imm_b;

    always_comb begin
        op1_next       = '0;
        op2_next       = '0;
        f3_next        = F3_ADD_SUB;
        f7_next        = F7_ZERO;
        br_f3_next     = in_f3;
        rd_next        = '0;
        is_alu_next    = 1'b0;
        is_branch_next = 1'b0;
        illegal_next   = 1'b0;
        case (opcode)
            OP_R: begin
                is_alu_next = 1'b1;
                rd_next     = in_instr[11:7];
                if (alu_f3_legal(in_f3)) begin
                    op1_next = in_rs1;
                    op2_next = in_rs2;
                    f3_next  = in_f3;
                    f7_next  = in_instr[31:25];
                end else begin
                    illegal_next = 1'b1;
                end
            end
            OP_I: begin
                // f7 stays zero so ADDI never turns into a subtract via imm bit 10.
                is_alu_next = 1'b1;
                rd_next     = in_instr[11:7];
                if (alu_f3_legal(in_f3)) begin
                    op1_next = in_rs1;
                    op2_next = imm_i;
                    f3_next  = in_f3;
                end else begin
                    illegal_next = 1'b1;
                end
            end
            OP_B: begin
                is_branch_next = 1'b1;
                op1_next       = in_rs1;
                op2_next       = in_rs2;
                f7_next        = F7_SUB;
                illegal_next   = !br_f3_legal(in_f3);
            end
            default: illegal_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            op1_reg       <= '0;
            op2_reg       <= '0;
            f3_reg        <= F3_ADD_SUB;
            f7_reg        <= F7_ZERO;
            br_f3_reg     <= '0;
            br_target_reg <= '0;
            rd_reg        <= '0;
            is_alu_reg    <= 1'b0;
            is_branch_reg <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            if (flush) begin
                s1_valid_reg <= 1'b0;
            end else if (in_ready) begin
                s1_valid_reg <= in_valid;
            end
            if (accept) begin
                op1_reg       <= op1_next;
                op2_reg       <= op2_next;
                f3_reg        <= f3_next;
                f7_reg        <= f7_next;
                br_f3_reg     <= br_f3_next;
                br_target_reg <= br_target_next;
                rd_reg        <= rd_next;
                is_alu_reg    <= is_alu_next;
                is_branch_reg <= is_branch_next;
                illegal_reg   <= illegal_next;
            end
        end
    end

    alu #(
        .SIZE(SIZE)
    ) u_alu (
        .rst    (1'b0),
        .f3     (f3_reg),
        .f7     (f7_reg),
        .op1    (op1_reg),
        .op2    (op2_reg),
        .result (alu_result),
        .c      (alu_c),
        .z      (alu_z),
        .n      (alu_n),
        .v      (alu_v_unused)
    );

    // Signed-compare overflow of the subtract; the ALU's own v is add-only.
    assign vs = (op1_reg[SIZE-1] ^ op2_reg[SIZE-1]) & (op1_reg[SIZE-1] ^ alu_result[SIZE-1]);

    always_comb begin
        case (br_f3_reg)
            F3_BEQ:  br_cond = alu_z;
            F3_BNE:  br_cond = !alu_z;
            F3_BLT:  br_cond = alu_n ^ vs;
            F3_BGE:  br_cond = !(alu_n ^ vs);
            F3_BLTU: br_cond = alu_c;
            F3_BGEU: br_cond = !alu_c;
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken = is_branch_reg & !illegal_reg & br_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_rd        <= '0;
            out_we        <= 1'b0;
            out_br_taken  <= 1'b0;
            out_br_target <= '0;
            out_illegal   <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (s2_adv) begin
                out_valid <= s1_valid_reg;
            end
            if (s2_adv && s1_valid_reg && !flush) begin
                out_result    <= alu_result;
                out_rd        <= rd_reg;
                out_we        <= is_alu_reg & !illegal_reg;
                out_br_taken  <= br_taken;
                out_br_target <= br_target_reg;
                out_illegal   <= illegal_reg;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed and randomized bench for alu_exec_stage with an in-order scoreboard.
module tb_alu_exec_stage;

    localparam int SIZE = 32;

    logic            clk;
    logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]     in_instr;
    logic [SIZE-1:0] in_pc, in_rs1, in_rs2, out_result, out_br_target;
    logic [4:0]      out_rd;
    logic            out_we, out_br_taken, out_illegal;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        taken;
        logic [31:0] target;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    int   checks = 0;
    int   failures = 0;
    int   n_txn = 0;

    alu_exec_stage #(.SIZE(SIZE)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_we        (out_we),
        .out_br_taken  (out_br_taken),
        .out_br_target (out_br_target),
        .out_illegal   (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] btarget(input logic [31:0] pc, input logic [31:0] instr);
        return pc + {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic exp_t mk(input logic [31:0] result, input logic [4:0] rd, input logic we,
                                input logic taken, input logic [31:0] target, input logic illegal);
        exp_t e;
        e.result = result; e.rd = rd; e.we = we; e.taken = taken; e.target = target; e.illegal = illegal;
        return e;
    endfunction

    // Reference behaviour written from the ISA semantics (direct comparisons).
    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] opb;
        logic [2:0]  f3;
        e = '0;
        f3 = instr[14:12];
        e.target = btarget(pc, instr);
        case (instr[6:0])
            7'b0110011, 7'b0010011: begin
                opb  = (instr[6:0] == 7'b0110011) ? b : {{20{instr[31]}}, instr[31:20]};
                e.rd = instr[11:7];
                case (f3)
                    3'b000:  e.result = (instr[6:0] == 7'b0110011 && instr[31:25] == 7'b0100000) ? a - opb : a + opb;
                    3'b111:  e.result = a & opb;
                    3'b110:  e.result = a | opb;
                    3'b100:  e.result = a ^ opb;
                    default: e.illegal = 1'b1;
                endcase
                e.we = !e.illegal;
            end
            7'b1100011: begin
                e.result = a - b;
                case (f3)
                    3'b000:  e.taken = (a == b);
                    3'b001:  e.taken = (a != b);
                    3'b100:  e.taken = ($signed(a) < $signed(b));
                    3'b101:  e.taken = ($signed(a) >= $signed(b));
                    3'b110:  e.taken = (a < b);
                    3'b111:  e.taken = (a >= b);
                    default: e.illegal = 1'b1;
                endcase
            end
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    // One clock: compare any consumed output, record any accepted input.
    task automatic step(output bit acc);
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            check("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                $display("txn %0d: result=%h rd=%0d we=%0b taken=%0b target=%h illegal=%0b",
                         n_txn, out_result, out_rd, out_we, out_br_taken, out_br_target, out_illegal);
                check($sformatf("txn%0d.result", n_txn), out_result, e.result);
                check($sformatf("txn%0d.rd", n_txn), out_rd, e.rd);
                check($sformatf("txn%0d.we", n_txn), out_we, e.we);
                check($sformatf("txn%0d.taken", n_txn), out_br_taken, e.taken);
                check($sformatf("txn%0d.target", n_txn), out_br_target, e.target);
                check($sformatf("txn%0d.illegal", n_txn), out_illegal, e.illegal);
                n_txn++;
            end
        end
        acc = in_valid && in_ready && !flush && !rst;
        if (acc) sb.push_back(pend);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input exp_t e);
        in_instr = instr; in_pc = pc; in_rs1 = a; in_rs2 = b; pend = e; in_valid = 1'b1;
    endtask

    task automatic wait_accept(input string tag, input bit rand_ready);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            step(acc);
        end
        check({tag, ".accept"}, acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic dsend(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input exp_t e);
        drive(instr, pc, a, b, e);
        wait_accept(tag, 1'b0);
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    initial begin
        bit          acc;
        logic [31:0] instr;
        exp_t        ea;
        rst = 0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; out_ready = 1;

        // Asynchronous reset takes effect between clock edges.
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst.out_valid", out_valid, 0);
        check("rst.in_ready", in_ready, 1);
        check("rst.out_result", out_result, 0);
        check("rst.out_rd", out_rd, 0);
        check("rst.out_we", out_we, 0);
        check("rst.out_br_taken", out_br_taken, 0);
        check("rst.out_br_target", out_br_target, 0);
        check("rst.out_illegal", out_illegal, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ADD latency: visible exactly one edge after accept.
        instr = enc_r(7'h00, 3'b000, 5'd3);
        dsend("add", instr, 32'h0, 32'd5, 32'd7, mk(32'd12, 5'd3, 1, 0, btarget(32'h0, instr), 0));
        check("lat.before", out_valid, 0);
        step(acc);
        check("lat.out_valid", out_valid, 1);
        check("lat.out_result", out_result, 32'd12);

        instr = enc_r(7'h20, 3'b000, 5'd4);
        dsend("sub", instr, 32'h0, 32'd3, 32'd5, mk(32'hFFFFFFFE, 5'd4, 1, 0, btarget(32'h0, instr), 0));
        instr = enc_i(12'hFFF, 3'b000, 5'd5);
        dsend("addi", instr, 32'h0, 32'd1, 32'd0, mk(32'h0, 5'd5, 1, 0, btarget(32'h0, instr), 0));
        dsend("blt", enc_b(13'h10, 3'b100), 32'h0, 32'hFFFFFFFF, 32'd1, mk(32'hFFFFFFFE, 0, 0, 1, 32'h10, 0));
        dsend("bltu", enc_b(13'h10, 3'b110), 32'h0, 32'hFFFFFFFF, 32'd1, mk(32'hFFFFFFFE, 0, 0, 0, 32'h10, 0));
        dsend("bge", enc_b(13'h10, 3'b101), 32'h0, 32'h80000000, 32'd1, mk(32'h7FFFFFFF, 0, 0, 0, 32'h10, 0));
        dsend("beq", enc_b(13'h10, 3'b000), 32'h0, 32'd9, 32'd9, mk(32'h0, 0, 0, 1, 32'h10, 0));
        dsend("bne_neg", enc_b(13'h1FF8, 3'b001), 32'h100, 32'd1, 32'd2, mk(32'hFFFFFFFF, 0, 0, 1, 32'hF8, 0));
        dsend("beq_wrap", enc_b(13'h0008, 3'b000), 32'hFFFFFFFC, 32'd1, 32'd2, mk(32'hFFFFFFFF, 0, 0, 0, 32'h4, 0));
        instr = 32'h00A00383;
        dsend("ill_op", instr, 32'h40, 32'd5, 32'd6, mk(32'h0, 0, 0, 0, btarget(32'h40, instr), 1));
        instr = enc_r(7'h00, 3'b001, 5'd6);
        dsend("ill_f3", instr, 32'h0, 32'd5, 32'd7, mk(32'h0, 5'd6, 0, 0, btarget(32'h0, instr), 1));
        dsend("ill_br", enc_b(13'h8, 3'b010), 32'h0, 32'd7, 32'd3, mk(32'h4, 0, 0, 0, 32'h8, 1));
        instr = enc_i(12'h0F0, 3'b111, 5'd8);
        dsend("andi", instr, 32'h0, 32'h12345678, 32'd0, mk(32'h70, 5'd8, 1, 0, btarget(32'h0, instr), 0));
        instr = enc_r(7'h00, 3'b110, 5'd9);
        dsend("or", instr, 32'h0, 32'hF0, 32'h0F, mk(32'hFF, 5'd9, 1, 0, btarget(32'h0, instr), 0));
        instr = enc_i(12'h800, 3'b100, 5'd10);
        dsend("xori", instr, 32'h0, 32'h0, 32'd0, mk(32'hFFFFF800, 5'd10, 1, 0, btarget(32'h0, instr), 0));
        idle(3);

        // Backpressure: one result held in stage 2, one buffered in stage 1.
        out_ready = 1'b0;
        instr = enc_r(7'h00, 3'b000, 5'd11);
        ea = mk(32'd30, 5'd11, 1, 0, btarget(32'h0, instr), 0);
        dsend("bp_a", instr, 32'h0, 32'd10, 32'd20, ea);
        instr = enc_r(7'h20, 3'b000, 5'd12);
        dsend("bp_b", instr, 32'h0, 32'd50, 32'd8, mk(32'd42, 5'd12, 1, 0, btarget(32'h0, instr), 0));
        instr = enc_i(12'h003, 3'b110, 5'd13);
        drive(instr, 32'h0, 32'h10, 32'd0, mk(32'h13, 5'd13, 1, 0, btarget(32'h0, instr), 0));
        for (int i = 0; i < 3; i++) begin
            step(acc);
            check("bp.accept_blocked", acc, 0);
            check("bp.in_ready", in_ready, 0);
            check("bp.out_valid", out_valid, 1);
            check("bp.out_result_stable", out_result, ea.result);
            check("bp.out_rd_stable", out_rd, ea.rd);
        end
        out_ready = 1'b1;
        wait_accept("bp_c", 1'b0);
        idle(3);

        // Flush beats a simultaneous accept and kills the in-flight instruction.
        instr = enc_r(7'h00, 3'b000, 5'd14);
        dsend("fl_x", instr, 32'h0, 32'd1, 32'd1, mk(32'd2, 5'd14, 1, 0, btarget(32'h0, instr), 0));
        instr = enc_r(7'h00, 3'b000, 5'd15);
        drive(instr, 32'h0, 32'd2, 32'd2, mk(32'd4, 5'd15, 1, 0, btarget(32'h0, instr), 0));
        flush = 1'b1;
        step(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush.accept", acc, 0);
        check("flush.out_valid", out_valid, 0);
        check("flush.in_ready", in_ready, 1);
        sb.delete();
        step(acc);
        check("flush.out_valid_after", out_valid, 0);

        // Reset mid-stream drops everything immediately.
        instr = enc_r(7'h00, 3'b000, 5'd16);
        dsend("rs_p", instr, 32'h0, 32'd3, 32'd4, mk(32'd7, 5'd16, 1, 0, btarget(32'h0, instr), 0));
        instr = enc_r(7'h00, 3'b111, 5'd17);
        dsend("rs_q", instr, 32'h0, 32'hFF, 32'h0F, mk(32'h0F, 5'd17, 1, 0, btarget(32'h0, instr), 0));
        check("rs.pre_out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("rs.out_valid", out_valid, 0);
        check("rs.in_ready", in_ready, 1);
        check("rs.out_result", out_result, 0);
        sb.delete();
        #1 rst = 1'b0;
        step(acc);
        check("rs.out_valid_after", out_valid, 0);

        // Random stream with random downstream stalls, checked against the model.
        for (int t = 0; t < 24; t++) begin
            logic [31:0] a, b, pc;
            int          kind;
            a    = $urandom;
            b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc   = $urandom & 32'hFFFFFFFC;
            kind = $urandom_range(0, 3);
            case (kind)
                0:       instr = enc_r(($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, 3'($urandom), 5'($urandom));
                1:       instr = enc_i(12'($urandom), 3'($urandom), 5'($urandom));
                2:       instr = enc_b(13'($urandom), 3'($urandom));
                default: instr = {25'($urandom), 7'b0100011};
            endcase
            drive(instr, pc, a, b, model(instr, pc, a, b));
            wait_accept($sformatf("rnd%0d", t), 1'b1);
        end
        out_ready = 1'b1;
        idle(4);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
